// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, per-item stock, vend and chunked change payout.
// Define VM_TIMEOUT_EN to refund credit automatically after TIMEOUT_CYC idle cycles in CREDIT.
module vending_machine_multi #(
    parameter int                         NUM_ITEMS   = 4,
    parameter int                         SEL_W       = 2,
    parameter int                         AMT_W       = 8,
    parameter logic [NUM_ITEMS*AMT_W-1:0] PRICES      = {8'd30, 8'd50, 8'd20, 8'd40},
    parameter int                         STOCK_W     = 4,
    parameter int                         STOCK_INIT  = 5,
    parameter int                         CHANGE_UNIT = 10,
    parameter int                         TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coin_valid,
    input  logic [AMT_W-1:0]     coin_value,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    output logic [AMT_W-1:0]     credit,
    output logic                 busy,
    output logic                 vend_valid,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 change_valid,
    output logic [AMT_W-1:0]     change_amt,
    output logic                 coin_reject,
    output logic                 err,
    output logic                 timeout,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic [15:0]          total_sales
);

    // state  | meaning
    // IDLE   | no credit, waiting for a coin
    // CREDIT | holding credit, accepting coins / selection / cancel
    // VEND   | one cycle: dispense, charge price, count sale
    // CHANGE | paying out remaining credit in CHANGE_UNIT chunks
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam logic [AMT_W-1:0]   UNIT      = AMT_W'(CHANGE_UNIT);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    state_t             state, state_nxt;
    logic [STOCK_W-1:0] stock [NUM_ITEMS];
    logic [AMT_W-1:0]   credit_nxt, change_amt_nxt, change_chunk;
    logic [AMT_W-1:0]   sel_price, vend_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               sel_hit, dec_en;
    logic               vend_valid_nxt, change_valid_nxt, coin_reject_nxt, err_nxt;
    logic [SEL_W-1:0]   vend_item_nxt;
    logic [15:0]        total_sales_nxt;
    logic [AMT_W:0]     coin_sum;

    always_comb begin
        sel_price  = '0;
        vend_price = '0;
        sel_stock  = '0;
        sel_hit    = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == SEL_W'(i)) begin
                sel_price = PRICES[i*AMT_W +: AMT_W];
                sel_stock = stock[i];
                sel_hit   = 1'b1;
            end
            if (vend_item == SEL_W'(i))
                vend_price = PRICES[i*AMT_W +: AMT_W];
            sold_out[i] = (stock[i] == '0);
        end
    end

    assign busy         = (state == VEND) || (state == CHANGE);
    assign change_chunk = (credit > UNIT) ? UNIT : credit;
    assign coin_sum     = {1'b0, credit} + {1'b0, coin_value};

`ifdef VM_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr;
    logic             timeout_nxt;

    // Reloads outside CREDIT or on any activity, so only uninterrupted idle time counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= TMR_W'(TIMEOUT_CYC - 1);
        else if (state != CREDIT || coin_valid || sel_valid || cancel)
            tmr <= TMR_W'(TIMEOUT_CYC - 1);
        else if (tmr != '0)
            tmr <= tmr - TMR_W'(1);
    end
`endif

    always_comb begin
        state_nxt        = state;
        credit_nxt       = credit;
        vend_valid_nxt   = 1'b0;
        vend_item_nxt    = vend_item;
        change_valid_nxt = 1'b0;
        change_amt_nxt   = '0;
        coin_reject_nxt  = 1'b0;
        err_nxt          = 1'b0;
        total_sales_nxt  = total_sales;
        dec_en           = 1'b0;
`ifdef VM_TIMEOUT_EN
        timeout_nxt      = 1'b0;
`endif
        case (state)
            IDLE, CREDIT: begin
                if (cancel) begin
                    coin_reject_nxt = coin_valid;
                    if (state == CREDIT)
                        state_nxt = CHANGE;
                end else if (sel_valid) begin
                    coin_reject_nxt = coin_valid;
                    if (state == CREDIT && sel_hit && credit >= sel_price && sel_stock != '0) begin
                        state_nxt      = VEND;
                        vend_valid_nxt = 1'b1;
                        vend_item_nxt  = sel_item;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum[AMT_W]) begin
                        coin_reject_nxt = 1'b1;
                    end else begin
                        credit_nxt = coin_sum[AMT_W-1:0];
                        state_nxt  = CREDIT;
                    end
                end
`ifdef VM_TIMEOUT_EN
                else if (state == CREDIT && tmr == '0) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = CHANGE;
                end
`endif
            end
            VEND: begin
                coin_reject_nxt = coin_valid;
                credit_nxt      = credit - vend_price;
                total_sales_nxt = total_sales + 16'(vend_price);
                dec_en          = 1'b1;
                state_nxt       = (credit != vend_price) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_nxt = coin_valid;
                if (credit != '0) begin
                    change_valid_nxt = 1'b1;
                    change_amt_nxt   = change_chunk;
                    credit_nxt       = credit - change_chunk;
                end
                if (credit <= UNIT)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            err          <= 1'b0;
            total_sales  <= '0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            vend_valid   <= vend_valid_nxt;
            vend_item    <= vend_item_nxt;
            change_valid <= change_valid_nxt;
            change_amt   <= change_amt_nxt;
            coin_reject  <= coin_reject_nxt;
            err          <= err_nxt;
            total_sales  <= total_sales_nxt;
        end
    end

    // Restock takes precedence over the decrement of a vend landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_RST;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock)
                    stock[i] <= STOCK_RST;
                else if (dec_en && vend_item == SEL_W'(i))
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

`ifdef VM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout <= 1'b0;
        else
            timeout <= timeout_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; expected values are hand-computed from the default prices.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, sel_valid, cancel, restock;
    logic [7:0] coin_value;
    logic [1:0] sel_item;
    logic [7:0] credit, change_amt;
    logic       busy, vend_valid, change_valid, coin_reject, err, timeout;
    logic [1:0] vend_item;
    logic [3:0] sold_out;
    logic [15:0] total_sales;

    int compared   = 0;
    int mismatched = 0;

    vending_machine_multi dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .restock(restock),
        .credit(credit), .busy(busy),
        .vend_valid(vend_valid), .vend_item(vend_item),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .err(err), .timeout(timeout),
        .sold_out(sold_out), .total_sales(total_sales)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic sel(input logic [1:0] i);
        sel_valid = 1'b1;
        sel_item  = i;
        step();
        sel_valid = 1'b0;
        sel_item  = '0;
    endtask

    int  n_chg, sum_chg;
    bit  saw_vend;

    initial begin
        rst_n = 1'b0; coin_valid = 0; coin_value = 0; sel_valid = 0; sel_item = 0;
        cancel = 0; restock = 0;
        #12;
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sold_out", sold_out, 0);
        chk("rst_total", total_sales, 0);
        chk("rst_change_amt", change_amt, 0);
        rst_n = 1'b1;

        // Two 50s, buy item 2 (50), refund 50 as five 10s
        coin(8'd50);
        chk("t1_credit50", credit, 50);
        coin(8'd50);
        chk("t1_credit100", credit, 100);
        sel(2'd2);
        chk("t1_vend_valid", vend_valid, 1);
        chk("t1_vend_item", vend_item, 2);
        chk("t1_busy_vend", busy, 1);
        step();
        chk("t1_vend_pulse_end", vend_valid, 0);
        chk("t1_credit_after_vend", credit, 50);
        chk("t1_total", total_sales, 50);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_change_valid", change_valid, 1);
            chk("t1_change_amt", change_amt, 10);
        end
        chk("t1_credit0", credit, 0);
        chk("t1_idle", busy, 0);
        step();
        chk("t1_change_off", change_valid, 0);
        chk("t1_change_amt_zero", change_amt, 0);

        // Credit 30 is short for item 0 (40); cancel refunds 30, coin during CHANGE rejected
        coin(8'd20);
        coin(8'd10);
        sel(2'd0);
        chk("t2_err", err, 1);
        chk("t2_credit30", credit, 30);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t2_busy_change", busy, 1);
        coin(8'd10);
        chk("t2_coin_reject_change", coin_reject, 1);
        chk("t2_chg1", change_amt, 10);
        step();
        chk("t2_chg2", change_amt, 10);
        step();
        chk("t2_chg3", change_amt, 10);
        chk("t2_credit0", credit, 0);
        chk("t2_idle", busy, 0);

        // Empty item 1 (price 20), then restock
        for (int k = 0; k < 5; k++) begin
            coin(8'd20);
            sel(2'd1);
            chk("t3_vend", vend_valid, 1);
            step();
            chk("t3_idle_after_vend", busy, 0);
        end
        chk("t3_sold_out", sold_out, 4'b0010);
        coin(8'd20);
        sel(2'd1);
        chk("t3_err_sold_out", err, 1);
        chk("t3_credit_kept", credit, 20);
        restock = 1'b1;
        step();
        restock = 1'b0;
        chk("t3_restocked", sold_out, 0);
        sel(2'd1);
        chk("t3_vend_after_restock", vend_valid, 1);
        step();
        chk("t3_total", total_sales, 170);

        // Overflow reject at 250, then cancel beats sel in the same cycle
        coin(8'd200);
        coin(8'd50);
        chk("t4_credit250", credit, 250);
        coin(8'd10);
        chk("t4_coin_reject", coin_reject, 1);
        chk("t4_credit_held", credit, 250);
        sel_valid = 1'b1; sel_item = 2'd3; cancel = 1'b1;
        step();
        sel_valid = 1'b0; sel_item = 2'd0; cancel = 1'b0;
        chk("t4_no_vend", vend_valid, 0);
        chk("t4_no_err", err, 0);
        chk("t4_busy", busy, 1);
        n_chg = 0; sum_chg = 0; saw_vend = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            step();
            if (change_valid) begin
                n_chg++;
                sum_chg += int'(change_amt);
            end
            if (vend_valid) saw_vend = 1;
        end
        chk("t4_chunks", n_chg, 25);
        chk("t4_refund_sum", sum_chg, 250);
        chk("t4_saw_vend", saw_vend, 0);
        chk("t4_drained", busy, 0);

        // 255 is the largest accepted credit; sel beats a coin in the same cycle
        coin(8'd200);
        coin(8'd55);
        chk("t4_credit255", credit, 255);
        coin(8'd1);
        chk("t4_reject_at_max", coin_reject, 1);
        sel_valid = 1'b1; sel_item = 2'd3; coin_valid = 1'b1; coin_value = 8'd10;
        step();
        sel_valid = 1'b0; sel_item = 2'd0; coin_valid = 1'b0; coin_value = 8'd0;
        chk("t4_prio_vend", vend_valid, 1);
        chk("t4_prio_coin_reject", coin_reject, 1);
        chk("t4_prio_item", vend_item, 3);
        step();
        chk("t4_credit225", credit, 225);
        chk("t4_total200", total_sales, 200);
        step();
        chk("t5_change_before_rst", change_valid, 1);
        chk("t5_credit215", credit, 215);

        // Asynchronous reset in the middle of CHANGE
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_change_valid", change_valid, 0);
        chk("t5_change_amt", change_amt, 0);
        chk("t5_credit", credit, 0);
        chk("t5_busy", busy, 0);
        chk("t5_total", total_sales, 0);
        chk("t5_vend_item", vend_item, 0);
        chk("t5_sold_out", sold_out, 0);
        #4;
        rst_n = 1'b1;
        step();
        chk("t5_stays_idle", busy, 0);

        // Inactivity in CREDIT
        coin(8'd20);
`ifdef VM_TIMEOUT_EN
        repeat (15) step();
        chk("t6_no_timeout_yet", timeout, 0);
        chk("t6_credit_held", credit, 20);
        step();
        chk("t6_timeout", timeout, 1);
        chk("t6_busy", busy, 1);
        step();
        chk("t6_chg1", change_amt, 10);
        chk("t6_timeout_pulse_end", timeout, 0);
        step();
        chk("t6_chg2", change_amt, 10);
        chk("t6_credit0", credit, 0);
        chk("t6_idle", busy, 0);
`else
        repeat (20) step();
        chk("t6_no_timeout", timeout, 0);
        chk("t6_credit_held", credit, 20);
        chk("t6_not_busy", busy, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
        chk("t6_chg1", change_amt, 10);
        step();
        chk("t6_chg2", change_amt, 10);
        chk("t6_credit0", credit, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL provide parameter NUM_ITEMS, default 4: number of selectable items.
REQ-002 SHALL provide parameter SEL_W, default 2: item select width, equal to ceil(log2(NUM_ITEMS)).
REQ-003 SHALL provide parameter AMT_W, default 8: width of all money values in Rs.
REQ-004 SHALL provide parameter PRICES, default {8'd30,8'd50,8'd20,8'd40}: packed NUM_ITEMS*AMT_W bits, item 0 in the LSBs (item0=40, item1=20, item2=50, item3=30).
REQ-005 SHALL provide parameter STOCK_W, default 4, and STOCK_INIT, default 5: per-item stock width and the value loaded at reset or restock.
REQ-006 SHALL provide parameter CHANGE_UNIT, default 10: maximum change paid out per cycle.
REQ-007 SHALL provide parameter TIMEOUT_CYC, default 16: inactivity limit in cycles.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 coin_valid / coin_value  in  1 / AMT_W  coin inserted this cycle, value in Rs.
REQ-011 sel_valid / sel_item  in  1 / SEL_W  item selection request.
REQ-012 cancel  in  1  refund request; restock  in  1  reload all stock.
REQ-013 credit  out  AMT_W  current credit; busy  out  1  high in VEND or CHANGE.
REQ-014 vend_valid / vend_item  out  1 / SEL_W  one-cycle dispense pulse and the item dispensed.
REQ-015 change_valid / change_amt  out  1 / AMT_W  one-cycle change payout chunk.
REQ-016 coin_reject, err, timeout  out  1 each  one-cycle pulses.
REQ-017 sold_out  out  NUM_ITEMS  bit i high while stock of item i is 0; total_sales  out  16  cumulative revenue.

Function
REQ-018 FSM states SHALL be IDLE, CREDIT, VEND and CHANGE.
REQ-019 IDLE/CREDIT: an accepted coin SHALL add coin_value to credit; IDLE goes to CREDIT.
REQ-020 A coin SHALL be accepted only if credit+coin_value <= 2^AMT_W-1; otherwise coin_reject pulses and credit is unchanged.
REQ-021 Coins SHALL be rejected (coin_reject) in VEND and CHANGE.
REQ-022 sel_valid in CREDIT with credit >= price and stock > 0 SHALL go to VEND; otherwise err pulses and the FSM stays in CREDIT.
REQ-023 sel_valid in IDLE SHALL pulse err.
REQ-024 VEND SHALL last one cycle, giving vend_valid the cycle after the accepted selection.
REQ-025 In VEND, the block SHALL decrement stock, subtract the price from credit and add the price to total_sales modulo 2^16.
REQ-026 VEND SHALL go to CHANGE if the remaining credit > 0, else to IDLE.
REQ-027 cancel in CREDIT SHALL go to CHANGE.
REQ-028 Priority in the same cycle SHALL be cancel > sel_valid > coin; a coin that loses SHALL pulse coin_reject.
REQ-029 CHANGE: each cycle change_valid=1 and change_amt=min(credit, CHANGE_UNIT), with credit reduced by change_amt; on reaching 0 the FSM goes to IDLE.
REQ-030 restock SHALL load STOCK_INIT into every item on the next edge in any state, and SHALL win over a simultaneous VEND decrement.
REQ-031 Pulse outputs SHALL be registered, and change_amt SHALL be 0 when change_valid is 0.

Reset
REQ-032 rst_n low SHALL immediately set state=IDLE, credit=0, total_sales=0, all pulses=0, busy=0, vend_item=0, change_amt=0 and all stock=STOCK_INIT.
REQ-033 Reset mid-VEND or mid-CHANGE SHALL discard the remaining credit without payout.

Configuration
REQ-034 Macro VM_TIMEOUT_EN defined: in CREDIT, a counter counts cycles with no coin_valid, sel_valid or cancel and clears on any of them; at TIMEOUT_CYC it pulses timeout and enters CHANGE to refund.
REQ-035 Macro VM_TIMEOUT_EN undefined: no counter exists, timeout SHALL be tied to 0, and CREDIT is held indefinitely.

Verification
REQ-036 Coins 50,50, then sel 2 -> vend_valid with item 2 next cycle; change 10 x5 over 5 cycles; total_sales=50; back in IDLE.
REQ-037 Credit 30, sel 0 -> err pulse, credit stays 30; then cancel -> change 10,10,10, credit 0.
REQ-038 Buy item 1 five times -> sold_out[1]=1; sixth attempt -> err; restock -> sold_out[1]=0.
REQ-039 Credit 250, coin 10 -> coin_reject, credit 250; simultaneous sel 3 + cancel with credit 250 -> refund only, no vend_valid.
REQ-040 rst_n low during CHANGE -> all outputs 0 at once, credit 0, stock=5 for all items.
REQ-041 VM_TIMEOUT_EN defined: credit 20, idle 16 cycles -> timeout pulse, change 10,10; undefined -> credit 20 held.
